// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the pipeline sequencer and the
// pipeline-register flush muxes.
//   state_t    : sequencer state encoding (RUN / MEM_WAIT / ERROR)
//   ctl_t      : bundle of register load enables and NOP-insert flushes
//   NOP_INSTR  : instruction word the flush muxes substitute (addi x0,x0,0)
//   run_ctl()  : load/flush decode for a non-frozen cycle
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
    logic ifid_flush;
    logic idex_flush;
  } ctl_t;

  // Decode for a cycle where the data memory is not holding the pipe.
  // A taken branch squashes both younger instructions, which also disposes
  // of any load-use hazard, so branch is checked first.
  function automatic ctl_t run_ctl(input logic branch, input logic load_use);
    ctl_t c;
    c            = '1;
    c.ifid_flush = 1'b0;
    c.idex_flush = 1'b0;
    if (branch) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, push a bubble into EX; older stages keep moving.
      c.pc         = 1'b0;
      c.ifid       = 1'b0;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator. Also used by the
// forwarding unit, so it carries no state and no clock.
//   rs1, rs2  : source registers of the instruction in ID
//   rd        : destination register of the instruction in EX
//   mem_read  : instruction in EX is a load
//   load_use  : ID needs a value the EX load has not produced yet
module hazard_detect import pipeline_pkg::*; #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_read,
  output logic                  load_use
);

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central sequencer for the PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. Resolves load-use stalls, taken-branch flushes and
// multi-cycle data-memory waits; a wait longer than WAIT_MAX cycles halts
// the pipe in ERROR until reset.
// Ports:
//   clk, rst (async, active low)
//   id_rs1/id_rs2/ex_rd/ex_mem_read : load-use hazard inputs
//   ex_branch_taken                 : branch resolved taken in EX
//   mem_access/mem_ready            : data-memory handshake from MEM
//   mem_req                         : data-memory request
//   *_load, ifid_flush, idex_flush  : pipeline register controls
//   mem_err                         : sticky wait-timeout error
//   stall_cycles                    : frozen/stalled cycle count (PERF_CNT_EN)
// Build option: define PERF_CNT_EN to add the stall_cycles counter/port.
module pipeline_ctrl import pipeline_pkg::*; #(
  parameter int REG_ADDR_W = 5,
  parameter int WAIT_MAX   = 15,
  parameter int WAIT_W     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_access,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  pc_load,
  output logic                  ifid_load,
  output logic                  idex_load,
  output logic                  exmem_load,
  output logic                  memwb_load,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  mem_err
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles
`endif
);

  if (WAIT_MAX < 1 || WAIT_MAX >= (1 << WAIT_W) || CNT_W < 1) begin : g_bad_cfg
    $error("pipeline_ctrl: WAIT_MAX must be 1..2^WAIT_W-1 and CNT_W >= 1");
  end

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              err_nxt;
  logic              load_use;
  logic              req;
  ctl_t              ctl, ctl_o;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rd       (ex_rd),
    .mem_read (ex_mem_read),
    .load_use (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_nxt   = mem_err;
    ctl       = '0;
    req       = 1'b0;
    case (state)
      RUN: begin
        req = mem_access;
        // An unfinished memory access freezes everything and masks
        // branch/load-use; they are re-evaluated on the ready cycle.
        if (mem_access && !mem_ready) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end else begin
          ctl = run_ctl(ex_branch_taken, load_use);
        end
      end
      MEM_WAIT: begin
        req = 1'b1;
        if (mem_ready) begin
          ctl       = run_ctl(ex_branch_taken, load_use);
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_LIM) begin
          state_nxt = ERROR;
          err_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      ERROR: begin
        err_nxt = 1'b1;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // Reset gates the outputs directly so they drop the moment rst falls,
  // aborting any in-flight memory request.
  assign ctl_o      = rst ? ctl : '0;
  assign mem_req    = rst & req;
  assign pc_load    = ctl_o.pc;
  assign ifid_load  = ctl_o.ifid;
  assign idex_load  = ctl_o.idex;
  assign exmem_load = ctl_o.exmem;
  assign memwb_load = ctl_o.memwb;
  assign ifid_flush = ctl_o.ifid_flush;
  assign idex_flush = ctl_o.idex_flush;

`ifdef PERF_CNT_EN
  // Counts every non-ERROR cycle the front end is held, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cycles <= '0;
    else if (!pc_load && state != ERROR && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked against a cycle model derived from
// the access/hazard rules (outstanding-access flag plus frozen-cycle count).
module tb_pipeline_ctrl;
  localparam int RA = 5, WMAX = 15, WW = 4, CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [RA-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic          mem_access = 1'b0, mem_ready = 1'b0;
  logic          mem_req, pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic          ifid_flush, idex_flush, mem_err;
`ifdef PERF_CNT_EN
  logic [CW-1:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.REG_ADDR_W(RA), .WAIT_MAX(WMAX), .WAIT_W(WW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_access      (mem_access),
    .mem_ready       (mem_ready),
    .mem_req         (mem_req),
    .pc_load         (pc_load),
    .ifid_load       (ifid_load),
    .idex_load       (idex_load),
    .exmem_load      (exmem_load),
    .memwb_load      (memwb_load),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .mem_err         (mem_err)
`ifdef PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  // model: error latched, access outstanding, frozen cycles of this access,
  // stall count
  bit m_err, m_pend;
  int m_k, m_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl_v();
    return {pc_load, ifid_load, idex_load, exmem_load, memwb_load, ifid_flush, idex_flush};
  endfunction

  function automatic int stall_now();
`ifdef PERF_CNT_EN
    return int'(stall_cycles);
`else
    return m_stall;
`endif
  endfunction

  // Called at the negedge: compare outputs, then advance the model across
  // the coming posedge (inputs are stable until after that edge).
  task automatic model_check();
    bit stalled, req, lu;
    logic [6:0] e;
    if (!rst) begin
      chk("rst_ctl", 32'(ctl_v()), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_err", 32'(mem_err), 32'd0);
      m_err = 0; m_pend = 0; m_k = 0; m_stall = 0;
`ifdef PERF_CNT_EN
      chk("rst_stall", 32'(stall_cycles), 32'd0);
`endif
      return;
    end
    lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (m_err) begin
      e = '0; req = 0; stalled = 1;
    end else begin
      req     = m_pend ? 1'b1 : mem_access;
      stalled = m_pend ? !mem_ready : (mem_access && !mem_ready);
      if (stalled)              e = 7'b0000000;
      else if (ex_branch_taken) e = 7'b1111111;
      else if (lu)              e = 7'b0011101;
      else                      e = 7'b1111100;
    end
    chk("ctl", 32'(ctl_v()), 32'(e));
    chk("req", 32'(mem_req), 32'(req));
    chk("err", 32'(mem_err), 32'(m_err));
`ifdef PERF_CNT_EN
    chk("stall", 32'(stall_cycles), 32'(m_stall));
`endif
    if (!m_err) begin
      if (!e[6] && m_stall < (1 << CW) - 1) m_stall++;
      if (stalled) begin
        m_k++;
        m_pend = 1;
        if (m_k > WMAX) m_err = 1;
      end else begin
        m_pend = 0;
        m_k    = 0;
      end
    end
  endtask

  task automatic cyc(input bit rs, ma, mr, br, mrd, input logic [RA-1:0] rd, r1, r2);
    @(posedge clk);
    #1;
    rst = rs; mem_access = ma; mem_ready = mr; ex_branch_taken = br;
    ex_mem_read = mrd; ex_rd = rd; id_rs1 = r1; id_rs2 = r2;
    @(negedge clk);
    model_check();
  endtask

  initial begin
    int sc0, n;
    // reset and release
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("release_loads", 32'(ctl_v()), 32'h7c);

    // load-use: one-cycle stall, bubble drops it, x0 never stalls
    cyc(1, 0, 0, 0, 1, 5, 1, 5);
    chk("lu_stall", 32'(ctl_v()), 32'h1d);
    cyc(1, 0, 0, 0, 0, 5, 1, 5);
    chk("lu_after", 32'(ctl_v()), 32'h7c);
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    chk("lu_rd0", 32'(ctl_v()), 32'h7c);

    // branch beats load-use
    cyc(1, 0, 0, 1, 1, 5, 5, 0);
    chk("br_lu", 32'(ctl_v()), 32'h7f);

    // three-cycle memory wait
    sc0 = stall_now();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      chk("wait_frozen", 32'(ctl_v()), 32'h0);
      chk("wait_req", 32'(mem_req), 32'd1);
    end
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    chk("wait_ready", 32'(ctl_v()), 32'h7c);
`ifdef PERF_CNT_EN
    chk("wait_stall3", 32'(stall_now() - sc0), 32'd3);
`endif

    // branch held through a two-cycle wait: flushes only on the ready cycle
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 1, 0, 0, 0, 0);
      chk("brwait_hold", 32'(ctl_v()), 32'h0);
    end
    cyc(1, 1, 1, 1, 0, 0, 0, 0);
    chk("brwait_ready", 32'(ctl_v()), 32'h7f);

    // reset mid-wait drops mem_req at once
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_req", 32'(mem_req), 32'd0);
    chk("rst_async_ctl", 32'(ctl_v()), 32'd0);
    @(negedge clk);
    model_check();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    // timeout: WAIT_MAX+1 frozen cycles then sticky error
    n = 0;
    for (int i = 0; i < 40 && !mem_err; i++) begin
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      if (!mem_err) n++;
    end
    chk("timeout_cycles", 32'(n), 32'(WMAX + 1));
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 1, 0, 0, 0, 0);
      chk("err_sticky", 32'(mem_err), 32'd1);
      chk("err_frozen", 32'(ctl_v()), 32'h0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("err_rst_clear", 32'(mem_err), 32'd0);
    @(negedge clk);
    model_check();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rs, ma, mr;
      rs = ($urandom_range(0, 199) != 0);
      ma = ($urandom_range(0, 2) == 0);
      mr = ($urandom_range(0, 2) != 0);
      cyc(rs, ma, mr, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
          RA'($urandom_range(0, 3)), RA'($urandom_range(0, 3)), RA'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
